serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walked LSB-first over WIDTH bits.
// Define SERIAL_ADDER_CTRL_OVF_EN to add the o_overflow port.

module full_adder (
  input  logic bit1,
  input  logic bit2,
  input  logic carry,
  output logic sum,
  output logic cout
);

  assign sum  = bit1 ^ bit2 ^ carry;
  assign cout = (bit1 & bit2) | (carry & (bit1 ^ bit2));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  output logic             o_cout,
  output logic             o_overflow
`else
  output logic             o_cout
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] r_next;

  full_adder u_fa (
    .bit1  (a_sh[0]),
    .bit2  (b_sh[0]),
    .carry (c_reg),
    .sum   (fa_sum),
    .cout  (fa_cout)
  );

  assign r_next = {fa_sum, r_sh[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_sum  <= '0;
      o_cout <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
      o_overflow <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            a_sh   <= i_a;
            b_sh   <= i_b;
            c_reg  <= i_cin;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          r_sh  <= r_next;
          c_reg <= fa_cout;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            o_sum  <= r_next;
            o_cout <= fa_cout;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            // c_reg is the carry into the MSB on the final bit
            o_overflow <= c_reg ^ fa_cout;
`endif
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and table-driven checks for serial_adder_ctrl (WIDTH 8 and 4).
// Overflow checks are compiled when SERIAL_ADDER_CTRL_OVF_EN is defined.

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic       ovf;
  logic       ovf4;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    .o_cout     (cout),
    .o_overflow (ovf)
`else
    .o_cout  (cout)
`endif
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start4),
    .i_a     (a4),
    .i_b     (b4),
    .i_cin   (cin4),
    .o_busy  (busy4),
    .o_done  (done4),
    .o_sum   (sum4),
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    .o_cout     (cout4),
    .o_overflow (ovf4)
`else
    .o_cout  (cout4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one WIDTH=8 op; reports cycles E0->done and whether
  // busy stayed high and o_sum held prev while running.
  task automatic run8(input logic [7:0] va,
                      input logic [7:0] vb,
                      input logic vc,
                      input logic [7:0] prev,
                      output int cyc,
                      output bit ok_busy,
                      output bit ok_hold);
    a = va;
    b = vb;
    cin = vc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va;
    b = ~vb;
    cin = ~vc;
    cyc = 0;
    ok_busy = 1'b1;
    ok_hold = 1'b1;
    while (!done && cyc < 20) begin
      if (busy !== 1'b1) ok_busy = 1'b0;
      if (sum !== prev) ok_hold = 1'b0;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    bit ok_busy;
    bit ok_hold;
    logic [7:0] prev;
    int ndone;
    int first;

    vecs[0] = '{8'h2D, 8'h1C, 1'b0, 8'h49, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    start4 = 1'b0;
    a4 = '0;
    b4 = '0;
    cin4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    prev = 8'h00;
    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, prev,
           cyc, ok_busy, ok_hold);
      chk($sformatf("lat%0d", i), cyc, 8);
      chk($sformatf("busy%0d", i), ok_busy, 1);
      chk($sformatf("hold%0d", i), ok_hold, 1);
      chk($sformatf("sum%0d", i), sum, vecs[i].sum);
      chk($sformatf("cout%0d", i), cout, vecs[i].cout);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
      chk($sformatf("ovf%0d", i), ovf, vecs[i].ovf);
`endif
      chk($sformatf("dbusy%0d", i), busy, 0);
      tick();
      chk($sformatf("dpulse%0d", i), done, 0);
      chk($sformatf("keep%0d", i), sum, vecs[i].sum);
      prev = vecs[i].sum;
    end

    // start pulse with new operands during RUN must be ignored
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        start = 1'b1;
        a = 8'hAA;
        b = 8'h33;
        cin = 1'b1;
      end
      tick();
      if (k == 3) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = k;
        chk("ign_sum", sum, 8'h30);
        chk("ign_cout", cout, 0);
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_lat", first, 8);
    chk("ign_idle", busy, 0);

    // reset at E4 aborts the op and clears the result
    a = 8'h55;
    b = 8'h55;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_nodone", ndone, 0);
    run8(8'h01, 8'h01, 1'b0, 8'h00, cyc, ok_busy, ok_hold);
    chk("fresh_lat", cyc, 8);
    chk("fresh_sum", sum, 8'h02);
    chk("fresh_cout", cout, 0);
    tick();

    // reset wins over a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    a = 8'h03;
    b = 8'h04;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rs_busy0", busy, 0);
    tick();
    chk("rs_busy1", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_sum", sum, 0);

    // exhaustive WIDTH=4 sweep, a start in every IDLE cycle
    ndone = 0;
    for (int i = 0; i < 512; i++) begin
      logic [4:0] exp5;
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ec;
      ea = 4'(i >> 5);
      eb = 4'(i >> 1);
      ec = i[0];
      exp5 = {1'b0, ea} + {1'b0, eb} + {4'b0, ec};
      a4 = ea;
      b4 = eb;
      cin4 = ec;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      cyc = 0;
      while (!done4 && cyc < 10) begin
        tick();
        cyc++;
      end
      if (done4) ndone++;
      chk($sformatf("w4_%0d", i), {cout4, sum4}, exp5);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
      chk($sformatf("w4ovf_%0d", i), ovf4,
          (ea[3] == eb[3]) && (exp5[3] != ea[3]));
`endif
      tick();
    end
    chk("w4_ndone", ndone, 512);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
